// File: rtl/lru_pkg.sv
// Shared defaults and index-width helper for the LRU age tracker slice.
package lru_pkg;

    localparam int DEF_WAYS  = 4;
    localparam int DEF_SETS  = 16;
    localparam int DEF_AGE_W = 8;

    // Index width for n entries; a single entry still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// Combinational victim pick for one set: lowest invalid way first, else oldest way.
module lru_victim_sel
    import lru_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int AGE_W = DEF_AGE_W
) (
    input  logic [WAYS*AGE_W-1:0]    ages,
    input  logic [WAYS-1:0]          valids,
    output logic [idx_w(WAYS)-1:0]   way,
    output logic                     was_invalid
);

    localparam int WW = idx_w(WAYS);

    logic            any_inv;
    logic [WW-1:0]   inv_way;
    logic [WW-1:0]   old_way;
    logic [AGE_W-1:0] best_age;

    always_comb begin
        any_inv = 1'b0;
        inv_way = '0;
        // Scan downward so the last hit, the lowest index, is kept.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valids[i]) begin
                any_inv = 1'b1;
                inv_way = WW'(i);
            end
        end

        old_way  = '0;
        best_age = ages[AGE_W-1:0];
        // Strict greater-than keeps ties on the lowest index.
        for (int i = 1; i < WAYS; i++) begin
            if (ages[i*AGE_W +: AGE_W] > best_age) begin
                best_age = ages[i*AGE_W +: AGE_W];
                old_way  = WW'(i);
            end
        end

        was_invalid = any_inv;
        way         = any_inv ? inv_way : old_way;
    end

endmodule

// File: rtl/lru_age_tracker.sv
// Per-set, per-way saturating age counters with valid bits and a registered victim query.
module lru_age_tracker
    import lru_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int SETS  = DEF_SETS,
    parameter int AGE_W = DEF_AGE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_valid,
    input  logic [idx_w(SETS)-1:0]   acc_set,
    input  logic [idx_w(WAYS)-1:0]   acc_way,
    input  logic                     inv_valid,
    input  logic [idx_w(SETS)-1:0]   inv_set,
    input  logic [idx_w(WAYS)-1:0]   inv_way,
    input  logic                     qry_valid,
    input  logic [idx_w(SETS)-1:0]   qry_set,
    output logic                     vic_valid,
    output logic [idx_w(WAYS)-1:0]   vic_way,
    output logic                     vic_was_invalid
);

    localparam int WW = idx_w(WAYS);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0] age_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];

    logic [WAYS*AGE_W-1:0] sel_ages;
    logic [WAYS-1:0]       sel_valids;
    logic [WW-1:0]         sel_way;
    logic                  sel_inv;

    // Query reads current state, so same-cycle updates are not visible to it.
    always_comb begin
        sel_ages   = '0;
        sel_valids = '0;
        for (int w = 0; w < WAYS; w++) begin
            sel_ages[w*AGE_W +: AGE_W] = age_q[qry_set][w];
            sel_valids[w]              = valid_q[qry_set][w];
        end
    end

    lru_victim_sel #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_victim_sel (
        .ages        (sel_ages),
        .valids      (sel_valids),
        .way         (sel_way),
        .was_invalid (sel_inv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= '0;
                end
                valid_q[s] <= '0;
            end
            vic_valid       <= 1'b0;
            vic_way         <= '0;
            vic_was_invalid <= 1'b0;
        end else begin
            vic_valid <= qry_valid;
            if (qry_valid) begin
                vic_way         <= sel_way;
                vic_was_invalid <= sel_inv;
            end

            if (acc_valid) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WW'(w) == acc_way) begin
                        age_q[acc_set][w]   <= '0;
                        valid_q[acc_set][w] <= 1'b1;
                    end else if (age_q[acc_set][w] != AGE_MAX) begin
                        age_q[acc_set][w] <= age_q[acc_set][w] + AGE_W'(1);
                    end
                end
            end

            // Placed last so an invalidate overrides an access to the same entry.
            if (inv_valid) begin
                age_q[inv_set][inv_way]   <= AGE_MAX;
                valid_q[inv_set][inv_way] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lru_age_tracker.sv
// Table-driven bench for lru_age_tracker with a queue scoreboard of per-cycle expectations.
module tb_lru_age_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       acc_valid;
    logic [3:0] acc_set;
    logic [1:0] acc_way;
    logic       inv_valid;
    logic [3:0] inv_set;
    logic [1:0] inv_way;
    logic       qry_valid;
    logic [3:0] qry_set;
    logic       vic_valid;
    logic [1:0] vic_way;
    logic       vic_was_invalid;

    lru_age_tracker #(
        .WAYS  (4),
        .SETS  (16),
        .AGE_W (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .acc_valid       (acc_valid),
        .acc_set         (acc_set),
        .acc_way         (acc_way),
        .inv_valid       (inv_valid),
        .inv_set         (inv_set),
        .inv_way         (inv_way),
        .qry_valid       (qry_valid),
        .qry_set         (qry_set),
        .vic_valid       (vic_valid),
        .vic_way         (vic_way),
        .vic_was_invalid (vic_was_invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       acc_v;
        logic [3:0] acc_s;
        logic [1:0] acc_w;
        logic       inv_v;
        logic [3:0] inv_s;
        logic [1:0] inv_w;
        logic       qry_v;
        logic [3:0] qry_s;
        logic [1:0] exp_way;
        logic       exp_inv;
    } vec_t;

    typedef struct {
        int         row;
        logic       valid;
        logic       was_rst;
        logic [1:0] way;
        logic       inv;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic r, input logic av, input int as, input int aw,
                                input logic iv, input int is_, input int iw,
                                input logic qv, input int qs, input int ew, input logic ei);
        vec_t v;
        v.rst = r;     v.acc_v = av; v.acc_s = 4'(as);  v.acc_w = 2'(aw);
        v.inv_v = iv;  v.inv_s = 4'(is_); v.inv_w = 2'(iw);
        v.qry_v = qv;  v.qry_s = 4'(qs);  v.exp_way = 2'(ew); v.exp_inv = ei;
        return v;
    endfunction

    task automatic add_acc(input int s, input int w);
        vecs.push_back(mk(0, 1, s, w, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic add_qry(input int s, input int ew, input logic ei);
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, s, ew, ei));
    endtask

    task automatic add_fill(input int s);
        for (int w = 0; w < 4; w++) add_acc(s, w);
    endtask

    task automatic cmp(input string name, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    // Monitor: one expectation per driven cycle, checked just after the edge that registers it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("vic_valid", e.row, int'(vic_valid), int'(e.valid));
                if (e.valid) begin
                    cmp("vic_way", e.row, int'(vic_way), int'(e.way));
                    cmp("vic_was_invalid", e.row, int'(vic_was_invalid), int'(e.inv));
                end else if (e.was_rst) begin
                    cmp("reset_vic_way", e.row, int'(vic_way), 0);
                    cmp("reset_vic_was_invalid", e.row, int'(vic_was_invalid), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b0; acc_valid = 1'b0; acc_set = '0; acc_way = '0;
        inv_valid = 1'b0; inv_set = '0; inv_way = '0; qry_valid = 1'b0; qry_set = '0;

        // Reset with concurrent access and query: no response.
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        add_qry(3, 0, 1);
        // Fill set 0 in order -> ages {3,2,1,0}.
        add_fill(0);
        add_qry(0, 0, 0);
        // Query sees pre-update state, then the post-update victim.
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add_qry(0, 1, 0);
        // Saturation at 3: after 3 hits on way 0 a wrapping counter would pick way 3.
        add_fill(1);
        for (int k = 0; k < 3; k++) add_acc(1, 0);
        add_qry(1, 1, 0);
        for (int k = 0; k < 2; k++) add_acc(1, 0);
        add_qry(1, 1, 0);
        // Set 0 must not have aged from the set 1 traffic.
        add_qry(0, 1, 0);
        // Same way access + invalidate: invalidate wins.
        add_fill(2);
        vecs.push_back(mk(0, 1, 2, 1, 1, 2, 1, 0, 0, 0, 0));
        add_qry(2, 1, 1);
        // Same set, different ways: both apply.
        add_fill(4);
        vecs.push_back(mk(0, 1, 4, 0, 1, 4, 2, 0, 0, 0, 0));
        add_qry(4, 2, 1);
        add_acc(4, 2);
        add_qry(4, 1, 0);
        // Idle cycle: no pulse.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Query immediately before a mid-sequence reset that carries access + query.
        add_qry(0, 1, 0);
        vecs.push_back(mk(1, 1, 5, 0, 1, 0, 1, 1, 5, 0, 0));
        // Back-to-back queries of every set after reset.
        for (int s = 0; s < 16; s++) add_qry(s, 0, 1);
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            acc_valid = vecs[i].acc_v; acc_set = vecs[i].acc_s; acc_way = vecs[i].acc_w;
            inv_valid = vecs[i].inv_v; inv_set = vecs[i].inv_s; inv_way = vecs[i].inv_w;
            qry_valid = vecs[i].qry_v; qry_set = vecs[i].qry_s;
            e.row     = i;
            e.valid   = vecs[i].qry_v && !vecs[i].rst;
            e.was_rst = vecs[i].rst;
            e.way     = vecs[i].exp_way;
            e.inv     = vecs[i].exp_inv;
            sb.push_back(e);
        end

        @(negedge clk);
        rst = 1'b0; acc_valid = 1'b0; inv_valid = 1'b0; qry_valid = 1'b0;
        repeat (3) @(negedge clk);
        cmp("scoreboard_drained", -1, sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
